// File: rtl/cpu19_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : cpu19_pkg                                                |
// | Description : CPU-wide constants shared by the 19-bit datapath blocks: |
// |               register data width, register file geometry and the     |
// |               writeback requester ids.                                 |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package cpu19_pkg;

    localparam int DATA_W    = 19;
    localparam int RF_ADDR_W = 4;
    localparam int RF_DEPTH  = 16;

    // Writeback requester ids (also the arbitration slot index)
    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_IO   = 2;

endpackage : cpu19_pkg
`default_nettype wire

// File: rtl/rf_wr_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : rf_wr_arbiter_pkg                                        |
// | Description : Local constants and types of the register-file write     |
// |               arbiter (requester count, pointer width, id type).       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package rf_wr_arbiter_pkg;

    // Number of writeback requesters (ALU, load, I/O)
    localparam int RR_NREQ = 3;

    // Round-robin pointer / requester id width. Two bits cover up to three
    // requesters with the wrap arithmetic used in the selector.
    localparam int PTR_W = 2;

    typedef logic [PTR_W-1:0] req_id_t;

endpackage : rf_wr_arbiter_pkg
`default_nettype wire

// File: rtl/rf_wr_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface   : rf_wr_arbiter_if                                         |
// | Description : Requester-side valid/ready bundle plus the registered    |
// |               register-file write port of rf_wr_arbiter.               |
// |   req_valid/req_addr/req_data : requester i presents a write (packed)  |
// |   req_ready                   : one-hot grant back to the requesters   |
// |   wr_stall                    : register file cannot accept a write    |
// |   wr_en/wr_sel/wr_data/wr_src : registered write towards the RF        |
// |   modport slave  : the arbiter                                          |
// |   modport master : requesters and register file around the arbiter     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
interface rf_wr_arbiter_if #(
    parameter int DATA_W = cpu19_pkg::DATA_W,
    parameter int ADDR_W = cpu19_pkg::RF_ADDR_W,
    parameter int NREQ   = rf_wr_arbiter_pkg::RR_NREQ
);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   wr_stall;
    logic                   wr_en;
    logic [2**ADDR_W-1:0]   wr_sel;
    logic [DATA_W-1:0]      wr_data;
    logic [1:0]             wr_src;

    modport slave (
        input  req_valid, req_addr, req_data, wr_stall,
        output req_ready, wr_en, wr_sel, wr_data, wr_src
    );

    modport master (
        output req_valid, req_addr, req_data, wr_stall,
        input  req_ready, wr_en, wr_sel, wr_data, wr_src
    );

endinterface : rf_wr_arbiter_if
`default_nettype wire

// File: rtl/rf_row_decoder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : rf_row_decoder                                           |
// | Description : Combinational N-to-2**N one-hot row decoder; address n   |
// |               drives bit n only.                                       |
// |   i_addr : row address                                                  |
// |   o_sel  : one-hot row select                                           |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module rf_row_decoder #(
    parameter int ADDR_W = 4
) (
    input  wire logic [ADDR_W-1:0]    i_addr,
    output logic      [2**ADDR_W-1:0] o_sel
);

    for (genvar n = 0; n < 2**ADDR_W; n++) begin : g_row
        assign o_sel[n] = (i_addr == ADDR_W'(n));
    end

endmodule : rf_row_decoder
`default_nettype wire

// File: rtl/rf_wr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : rf_wr_arbiter                                            |
// | Description : Round-robin arbiter for the single register-file write   |
// |               port. Grants one of NREQ writeback requesters per cycle  |
// |               (combinational one-hot req_ready) and registers the      |
// |               winning write with a decoded one-hot row select.         |
// |   clk, rst : clock, synchronous active-high reset                      |
// |   bus      : rf_wr_arbiter_if.slave (requesters + RF write port)       |
// | Build option: RF_R0_ZERO_EN - register 0 is hardwired to zero; writes  |
// |               to address 0 are accepted but never strobe the RF.       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module rf_wr_arbiter
    import rf_wr_arbiter_pkg::*;
#(
    parameter int DATA_W = cpu19_pkg::DATA_W,
    parameter int ADDR_W = cpu19_pkg::RF_ADDR_W,
    parameter int NREQ   = RR_NREQ
) (
    input wire logic        clk,
    input wire logic        rst,
    rf_wr_arbiter_if.slave  bus
);

    req_id_t              r_ptr;
    logic                 r_wr_en;
    logic [2**ADDR_W-1:0] r_wr_sel;
    logic [DATA_W-1:0]    r_wr_data;
    req_id_t              r_wr_src;

    logic [NREQ-1:0]      w_grant;
    logic                 w_any;
    req_id_t              w_gidx;
    req_id_t              w_idx;
    logic [ADDR_W-1:0]    w_addr;
    logic [DATA_W-1:0]    w_data;
    logic [2**ADDR_W-1:0] w_dec;
    logic                 w_r0;

    // Search ptr, ptr+1, ... modulo NREQ; the first valid requester wins.
    // The wrap is done as a compare/subtract so everything stays PTR_W wide.
    always_comb begin
        w_grant = '0;
        w_any   = 1'b0;
        w_gidx  = '0;
        w_idx   = '0;
        if (!rst && !bus.wr_stall) begin
            for (int k = 0; k < NREQ; k++) begin
                if (r_ptr >= PTR_W'(NREQ) - PTR_W'(k))
                    w_idx = r_ptr - (PTR_W'(NREQ) - PTR_W'(k));
                else
                    w_idx = r_ptr + PTR_W'(k);
                if (!w_any && bus.req_valid[w_idx]) begin
                    w_any           = 1'b1;
                    w_gidx          = w_idx;
                    w_grant[w_idx]  = 1'b1;
                end
            end
        end
    end

    assign w_addr = bus.req_addr[w_gidx*ADDR_W +: ADDR_W];
    assign w_data = bus.req_data[w_gidx*DATA_W +: DATA_W];

`ifdef RF_R0_ZERO_EN
    assign w_r0 = (w_addr == '0);
`else
    assign w_r0 = 1'b0;
`endif

    rf_row_decoder #(
        .ADDR_W (ADDR_W)
    ) u_row_decoder (
        .i_addr (w_addr),
        .o_sel  (w_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= PTR_W'(cpu19_pkg::REQ_ALU);
            r_wr_en   <= 1'b0;
            r_wr_sel  <= '0;
            r_wr_data <= '0;
            r_wr_src  <= '0;
        end else if (w_any) begin
            r_ptr     <= (w_gidx == PTR_W'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
            // An R0 write still completes the handshake but never reaches
            // the register file when R0 is hardwired.
            r_wr_en   <= !w_r0;
            r_wr_sel  <= w_r0 ? '0 : w_dec;
            r_wr_data <= w_data;
            r_wr_src  <= w_gidx;
        end else begin
            r_wr_en   <= 1'b0;
            r_wr_sel  <= '0;
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_sel    = r_wr_sel;
    assign bus.wr_data   = r_wr_data;
    assign bus.wr_src    = r_wr_src;

endmodule : rf_wr_arbiter
`default_nettype wire

// File: tb/tb_rf_wr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_rf_wr_arbiter                                         |
// | Description : Self-checking bench for rf_wr_arbiter. A round-robin     |
// |               reference model predicts each cycle's grant and pushes   |
// |               the expected registered write to a scoreboard queue,     |
// |               which is popped and compared after the clock edge.       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_rf_wr_arbiter;

    localparam int NR = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [NR-1:0]    tv    = '0;
    logic [NR*4-1:0]  ta    = '0;
    logic [NR*19-1:0] td    = '0;
    logic             stall = 1'b0;

    rf_wr_arbiter_if bus ();

    assign bus.req_valid = tv;
    assign bus.req_addr  = ta;
    assign bus.req_data  = td;
    assign bus.wr_stall  = stall;

    rf_wr_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic [15:0] sel;
        logic [18:0] data;
        logic [1:0]  src;
    } exp_t;

    exp_t q[$];

    int          n_checks = 0;
    int          n_errors = 0;
    int          m_ptr    = 0;
    logic [18:0] m_data   = '0;
    logic [1:0]  m_src    = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [3:0] a, input logic [18:0] d);
        tv[i]          = 1'b1;
        ta[i*4 +: 4]   = a;
        td[i*19 +: 19] = d;
    endtask

    // One clock cycle: predict/check the grant, push the expected write,
    // cross the edge, pop/check the write, then retire (or refill) the winner.
    task automatic step(input bit keep);
        int         g;
        exp_t       e;
        logic [3:0] a;
        logic [2:0] rdy;
        #1;
        g   = (rst || stall) ? -1 : pick(tv, m_ptr);
        rdy = (g >= 0) ? (3'b001 << g) : 3'b000;
        chk("req_ready", 32'(bus.req_ready), 32'(rdy));
        e = '0;
        if (rst) begin
            m_ptr  = 0;
            m_data = '0;
            m_src  = '0;
        end else if (g >= 0) begin
            a      = ta[g*4 +: 4];
            m_data = td[g*19 +: 19];
            m_src  = 2'(g);
            e.en   = 1'b1;
            e.sel  = 16'h0001 << a;
`ifdef RF_R0_ZERO_EN
            if (a == 4'd0) begin
                e.en  = 1'b0;
                e.sel = '0;
            end
`endif
            m_ptr = (g + 1) % NR;
        end
        e.data = m_data;
        e.src  = m_src;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("wr_en",   32'(bus.wr_en),   32'(e.en));
        chk("wr_sel",  32'(bus.wr_sel),  32'(e.sel));
        chk("wr_data", 32'(bus.wr_data), 32'(e.data));
        chk("wr_src",  32'(bus.wr_src),  32'(e.src));
        if (g >= 0 && !rst) begin
            if (keep) set_req(g, 4'($urandom_range(0, 15)), 19'($urandom));
            else      tv[g] = 1'b0;
        end
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        step(0);
        step(0);
        rst = 1'b0;

        // Single ALU write to addr 5
        set_req(0, 4'd5, 19'h12345);
        step(0);
        chk("t1_sel",  32'(bus.wr_sel),  32'h0020);
        chk("t1_data", 32'(bus.wr_data), 32'h12345);
        chk("t1_src",  32'(bus.wr_src),  32'd0);

        // All three continuously valid from reset: 0,1,2,0,1,2
        rst = 1'b1;
        step(0);
        rst = 1'b0;
        set_req(0, 4'd1, 19'h00111);
        set_req(1, 4'd2, 19'h00222);
        set_req(2, 4'd3, 19'h00333);
        repeat (6) step(1);
        repeat (3) step(0);

        // ptr -> 2 via a lone load grant, then 0 and 2 both target addr 9
        set_req(1, 4'd3, 19'h0abcd);
        step(0);
        set_req(0, 4'd9, 19'h1aaaa);
        set_req(2, 4'd9, 19'h2bbbb);
        step(0);
        chk("t3_first", 32'(bus.wr_data), 32'h2bbbb);
        step(0);
        chk("t3_final", 32'(bus.wr_data), 32'h1aaaa);

        // Three stalled cycles with load valid, then grant
        set_req(1, 4'd7, 19'h07777);
        stall = 1'b1;
        repeat (3) step(0);
        stall = 1'b0;
        step(0);
        chk("t4_src", 32'(bus.wr_src), 32'd1);

        // Grant to I/O, then reset the next cycle with everyone valid
        set_req(2, 4'd4, 19'h04444);
        step(0);
        set_req(0, 4'd6, 19'h06666);
        set_req(1, 4'd8, 19'h08888);
        set_req(2, 4'd10, 19'h0aaaa);
        rst = 1'b1;
        step(0);
        chk("t5_rst_en", 32'(bus.wr_en), 32'd0);
        rst = 1'b0;
        step(0);
        chk("t5_src", 32'(bus.wr_src), 32'd0);
        repeat (2) step(0);

        // Write to address 0
        set_req(1, 4'd0, 19'h07abc);
        step(0);
`ifdef RF_R0_ZERO_EN
        chk("t6_en",  32'(bus.wr_en),  32'd0);
        chk("t6_sel", 32'(bus.wr_sel), 32'h0000);
`else
        chk("t6_en",  32'(bus.wr_en),  32'd1);
        chk("t6_sel", 32'(bus.wr_sel), 32'h0001);
`endif

        // Random traffic respecting the hold-until-accepted rule
        repeat (40) begin
            for (int i = 0; i < NR; i++) begin
                if (!tv[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 4'($urandom_range(0, 15)), 19'($urandom));
            end
            stall = ($urandom_range(0, 3) == 0);
            step(0);
        end
        stall = 1'b0;
        repeat (4) step(0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_rf_wr_arbiter
`default_nettype wire
